// File: rtl/pipelined_shift_unit.sv
// Two-stage pipelined shift/normalise unit with valid/ready handshakes.
// Stage 1 registers the operand, the NORM leading-zero count and a partial
// shift by the upper amount bits; stage 2 finishes the shift with the lower
// amount bits, derives carry/zero/count and holds the result under backpressure.
module pipelined_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_cnt,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_NORM = 3'b101,
        OP_RSV0 = 3'b110,
        OP_RSV1 = 3'b111
    } op_e;

    localparam int               LO      = AMT_W / 2;
    localparam logic [AMT_W-1:0] W_AMT   = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] LO_MASK = AMT_W'((1 << LO) - 1);

    // One shifter shared by both stages; rotate amounts are always < WIDTH here.
    function automatic logic [WIDTH-1:0] f_shift(input op_e op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [AMT_W-1:0] a);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        dbl = {x, x};
        res = x;
        case (op)
            OP_SLL, OP_NORM: res = x << a;
            OP_SRL:          res = x >> a;
            OP_SRA:          res = $signed(x) >>> a;
            OP_ROL: begin
                dbl = {x, x} << a;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = {x, x} >> a;
                res = dbl[WIDTH-1:0];
            end
            default:         res = x;
        endcase
        return res;
    endfunction

    logic             w_s1_adv;
    logic             w_s2_adv;
    op_e              w_op;
    logic [AMT_W-1:0] w_lzc;
    logic [AMT_W-1:0] w_rot;
    logic [AMT_W-1:0] w_amt_eff;
    logic [WIDTH-1:0] w_s1_part;

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_part;
    logic [AMT_W-1:0] r_s1_k;
    logic [AMT_W-1:0] r_s1_eff;

    logic [WIDTH-1:0] w_s2_data;
    logic [WIDTH-1:0] w_sll_sh;
    logic [WIDTH-1:0] w_srl_sh;
    logic             w_s2_carry;
    logic             w_s2_err;
    logic [AMT_W-1:0] w_s2_cnt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [AMT_W-1:0] r_out_cnt;
    logic             r_out_carry;
    logic             r_out_zero;
    logic             r_out_err;

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_op  = op_e'(in_op);
    assign w_rot = in_amt % W_AMT;

    // Leading-zero count of the incoming operand (WIDTH when all zero)
    always_comb begin
        w_lzc = W_AMT;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_data[i]) w_lzc = AMT_W'(WIDTH - 1 - i);
        end
    end

    // Effective amount per op and the partial shift by its upper bits
    always_comb begin
        case (w_op)
            OP_ROL, OP_ROR: w_amt_eff = w_rot;
            OP_NORM:        w_amt_eff = w_lzc;
            default:        w_amt_eff = in_amt;
        endcase
        w_s1_part = f_shift(w_op, in_data, w_amt_eff & ~LO_MASK);
    end

    // Stage 1 register: loads only when the slot is free or draining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_SLL;
            r_s1_x     <= '0;
            r_s1_part  <= '0;
            r_s1_k     <= '0;
            r_s1_eff   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op   <= w_op;
                r_s1_x    <= in_data;
                r_s1_part <= w_s1_part;
                r_s1_k    <= in_amt;
                r_s1_eff  <= w_amt_eff;
            end
        end
    end

    // Finish the shift with the lower amount bits and derive count/carry/err
    always_comb begin
        w_s2_data  = f_shift(r_s1_op, r_s1_part, r_s1_eff & LO_MASK);
        // bit 0 of these is x[WIDTH-k] / x[k-1] whenever 1 <= k <= WIDTH
        w_sll_sh   = r_s1_x >> (W_AMT - r_s1_k);
        w_srl_sh   = r_s1_x >> (r_s1_k - AMT_W'(1));
        w_s2_carry = 1'b0;
        w_s2_err   = 1'b0;
        w_s2_cnt   = '0;
        case (r_s1_op)
            OP_SLL: begin
                w_s2_cnt = (r_s1_k > W_AMT) ? W_AMT : r_s1_k;
                if (r_s1_k != '0 && r_s1_k <= W_AMT) w_s2_carry = w_sll_sh[0];
            end
            OP_SRL: begin
                w_s2_cnt = (r_s1_k > W_AMT) ? W_AMT : r_s1_k;
                if (r_s1_k != '0 && r_s1_k <= W_AMT) w_s2_carry = w_srl_sh[0];
            end
            OP_SRA: begin
                w_s2_cnt = (r_s1_k > W_AMT) ? W_AMT : r_s1_k;
                if (r_s1_k > W_AMT)      w_s2_carry = r_s1_x[WIDTH-1];
                else if (r_s1_k != '0)   w_s2_carry = w_srl_sh[0];
            end
            OP_ROL: begin
                w_s2_cnt   = r_s1_eff;
                w_s2_carry = (r_s1_eff != '0) & w_s2_data[0];
            end
            OP_ROR: begin
                w_s2_cnt   = r_s1_eff;
                w_s2_carry = (r_s1_eff != '0) & w_s2_data[WIDTH-1];
            end
            OP_NORM: w_s2_cnt = r_s1_eff;
            default: w_s2_err = 1'b1;
        endcase
    end

    // Output register: holds its contents while the consumer stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data  <= w_s2_data;
                r_out_cnt   <= w_s2_cnt;
                r_out_carry <= w_s2_carry;
                r_out_zero  <= (w_s2_data == '0) & ~w_s2_err;
                r_out_err   <= w_s2_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign out_carry = r_out_carry;
    assign out_zero  = r_out_zero;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Bench for pipelined_shift_unit: bit-serial reference model, cycle-level
// occupancy/latency model and a single negedge compare process.
module tb_pipelined_shift_unit;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_cnt;
    logic          out_carry;
    logic          out_zero;
    logic          out_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipelined_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cnt(out_cnt),
        .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [AW-1:0] cnt;
        logic          c;
        logic          z;
        logic          e;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } ent_t;

    // Reference: shift one bit at a time, carry is the last bit that fell off
    function automatic res_t model(input logic [W-1:0] x, input logic [2:0] op,
                                   input logic [AW-1:0] k);
        res_t        r;
        logic [W-1:0] d;
        int unsigned n;
        d = x; r.c = 1'b0; r.e = 1'b0; n = 0;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                for (int unsigned i = 0; i < k; i++) begin
                    if (op == 3'd0) begin r.c = d[W-1]; d = d << 1; end
                    else if (op == 3'd1) begin r.c = d[0]; d = d >> 1; end
                    else begin r.c = d[0]; d = {d[W-1], d[W-1:1]}; end
                end
                if (k > AW'(W)) n = W; else n = k;
            end
            3'd3: begin
                n = k % W;
                for (int unsigned i = 0; i < n; i++) d = {d[W-2:0], d[W-1]};
                r.c = (n != 0) ? d[0] : 1'b0;
            end
            3'd4: begin
                n = k % W;
                for (int unsigned i = 0; i < n; i++) d = {d[0], d[W-1:1]};
                r.c = (n != 0) ? d[W-1] : 1'b0;
            end
            3'd5: begin
                while (n < W && d[W-1] == 1'b0) begin d = d << 1; n++; end
            end
            default: r.e = 1'b1;
        endcase
        r.d   = d;
        r.cnt = AW'(n);
        r.z   = (d == '0) && !r.e;
        return r;
    endfunction

    // Compare process and scoreboard
    ent_t q[$];
    int   cyc = 0;
    int   last_leave = -100;
    int   n_acc = 0, n_out = 0, first_acc = 0, first_out = 0, last_out = 0;

    always @(negedge clk) begin
        int   appear;
        logic exp_valid;
        logic exp_ready;
        ent_t e;
        cyc++;
        if (!reset) begin
            q.delete();
            last_leave = -100;
            tests++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_carry !== 1'b0 ||
                out_zero !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_state: got v=%b d=%h cnt=%0d c=%b z=%b e=%b rdy=%b, want all 0 rdy=1",
                         out_valid, out_data, out_cnt, out_carry, out_zero, out_err, in_ready);
            end
        end else begin
            exp_ready = !(q.size() == 2 && !out_ready);
            tests++;
            if (in_ready !== exp_ready) begin
                fails++;
                $display("FAIL in_ready @%0d: got %b want %b (occupancy %0d)", cyc, in_ready, exp_ready, q.size());
            end
            exp_valid = 1'b0;
            if (q.size() > 0) begin
                appear = q[0].acc + 2;
                if (last_leave + 1 > appear) appear = last_leave + 1;
                exp_valid = (cyc >= appear);
            end
            tests++;
            if (out_valid !== exp_valid) begin
                fails++;
                $display("FAIL out_valid @%0d: got %b want %b", cyc, out_valid, exp_valid);
            end
            if (out_valid && exp_valid) begin
                tests++;
                if (out_data !== q[0].r.d || out_cnt !== q[0].r.cnt || out_carry !== q[0].r.c ||
                    out_zero !== q[0].r.z || out_err !== q[0].r.e) begin
                    fails++;
                    $display("FAIL result @%0d: got d=%h cnt=%0d c=%b z=%b e=%b want d=%h cnt=%0d c=%b z=%b e=%b",
                             cyc, out_data, out_cnt, out_carry, out_zero, out_err,
                             q[0].r.d, q[0].r.cnt, q[0].r.c, q[0].r.z, q[0].r.e);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                last_leave = cyc;
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
            if (in_valid && in_ready) begin
                e.r   = model(in_data, in_op, in_amt);
                e.acc = cyc;
                q.push_back(e);
                if (n_acc == 0) first_acc = cyc;
                n_acc++;
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Called one time unit after a rising edge; returns the same way after acceptance
    task automatic send(input logic [W-1:0] x, input logic [2:0] op, input logic [AW-1:0] k);
        bit ok = 0;
        in_valid = 1'b1; in_data = x; in_op = op; in_amt = k;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("send_accept", int'(ok), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic vec(input string nm, input logic [W-1:0] x, input logic [2:0] op,
                       input logic [AW-1:0] k, input logic [W-1:0] ed, input logic [AW-1:0] ec,
                       input logic eca, input logic ez, input logic ee);
        res_t m;
        int   t;
        bit   seen = 0;
        m = model(x, op, k);
        tests++;
        if (m.d !== ed || m.cnt !== ec || m.c !== eca || m.z !== ez || m.e !== ee) begin
            fails++;
            $display("FAIL model_%s: got d=%h cnt=%0d c=%b z=%b e=%b want d=%h cnt=%0d c=%b z=%b e=%b",
                     nm, m.d, m.cnt, m.c, m.z, m.e, ed, ec, eca, ez, ee);
        end
        out_ready = 1'b1;
        send(x, op, k);
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
        end
        check({nm, "_latency"}, seen ? t : 99, 1);
        tests++;
        if (out_data !== ed || out_cnt !== ec || out_carry !== eca || out_zero !== ez || out_err !== ee) begin
            fails++;
            $display("FAIL dut_%s: got d=%h cnt=%0d c=%b z=%b e=%b want d=%h cnt=%0d c=%b z=%b e=%b",
                     nm, out_data, out_cnt, out_carry, out_zero, out_err, ed, ec, eca, ez, ee);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b0;
        #22 reset = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        vec("sll_k1",   16'h8001, 3'd0, 5'd1,  16'h0002, 5'd1,  1, 0, 0);
        vec("sll_k17",  16'h8001, 3'd0, 5'd17, 16'h0000, 5'd16, 0, 1, 0);
        vec("sra_k3",   16'h8004, 3'd2, 5'd3,  16'hF000, 5'd3,  1, 0, 0);
        vec("sra_k20",  16'h8004, 3'd2, 5'd20, 16'hFFFF, 5'd16, 1, 0, 0);
        vec("srl_k16",  16'h8004, 3'd1, 5'd16, 16'h0000, 5'd16, 1, 1, 0);
        vec("rol_k17",  16'h8001, 3'd3, 5'd17, 16'h0003, 5'd1,  1, 0, 0);
        vec("ror_k16",  16'h0001, 3'd4, 5'd16, 16'h0001, 5'd0,  0, 0, 0);
        vec("norm_13",  16'h0013, 3'd5, 5'd7,  16'h9800, 5'd11, 0, 0, 0);
        vec("norm_0",   16'h0000, 3'd5, 5'd3,  16'h0000, 5'd16, 0, 1, 0);
        vec("rsv_110",  16'h1234, 3'd6, 5'd3,  16'h1234, 5'd0,  0, 0, 1);

        // Back-to-back stream, then fill under backpressure
        out_ready = 1'b1;
        n_acc = 0; n_out = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_op    = 3'($urandom_range(0, 5));
            in_amt   = AW'($urandom_range(0, 31));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_accepts", n_acc, 8);
        check("b2b_results", n_out, 8);
        check("b2b_first_latency", first_out - first_acc, 2);
        check("b2b_consecutive", last_out - first_out, 7);

        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_op    = 3'($urandom_range(0, 5));
            in_amt   = AW'($urandom_range(0, 31));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stall_accepts", n_acc, 2);
        @(negedge clk);
        held = out_data;
        repeat (3) @(negedge clk);
        check("stall_hold", int'(out_data), int'(held));
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with two results in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00F0; in_op = 3'd0; in_amt = 5'd2;
        @(posedge clk); #1;
        in_data = 16'h0F00; in_op = 3'd1; in_amt = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        check("pre_reset_valid", int'(out_valid), 1);
        reset = 1'b0;
        #1;
        check("async_reset_valid", int'(out_valid), 0);
        check("async_reset_data", int'(out_data), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        vec("post_reset", 16'h0013, 3'd5, 5'd0, 16'h9800, 5'd11, 0, 0, 0);

        // Randomised traffic with random backpressure
        for (int cy = 0; cy < 600; cy++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_amt    = AW'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       in_data = '0;
                1:       in_data = W'(1) << $urandom_range(0, W - 1);
                2:       in_data = W'($urandom_range(0, 255));
                default: in_data = W'($urandom);
            endcase
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
